// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: chained-digit BCD up/down counter with wrap/saturate ends,
// clamped parallel load and registered one-cycle NEXT/PREV wrap pulses.
module bcd_updown_counter #(
    parameter int DIGITS   = 4,
    parameter int SATURATE = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  up_i,
    input  logic                  down_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    output logic [4*DIGITS-1:0]   out_o,
    output logic                  next_o,
    output logic                  prev_o,
    output logic                  at_max_o,
    output logic                  at_min_o
);
    logic [4*DIGITS-1:0] out_q, out_d, inc_v, dec_v, clamp_v;
    logic                next_q, next_d, prev_q, prev_d;
    logic [DIGITS:0]     all9, all0;
    logic                do_up, do_dn;

    assign all9[0] = 1'b1;
    assign all0[0] = 1'b1;

    // all9[i]/all0[i]: every digit below i is 9/0, i.e. digit i receives the carry/borrow
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [3:0] d, l;
        assign d = out_q[4*i +: 4];
        assign l = load_val_i[4*i +: 4];
        assign all9[i+1] = all9[i] && d == 4'd9;
        assign all0[i+1] = all0[i] && d == 4'd0;
        assign inc_v[4*i +: 4] = !all9[i] ? d : d == 4'd9 ? 4'd0 : d + 4'd1;
        assign dec_v[4*i +: 4] = !all0[i] ? d : d == 4'd0 ? 4'd9 : d - 4'd1;
        assign clamp_v[4*i +: 4] = l > 4'd9 ? 4'd9 : l;
    end

    assign at_max_o = all9[DIGITS];
    assign at_min_o = all0[DIGITS];
    assign do_up = en_i && up_i && !down_i && !(SATURATE != 0 && at_max_o);
    assign do_dn = en_i && down_i && !up_i && !(SATURATE != 0 && at_min_o);

    always_comb begin
        out_d  = load_i ? clamp_v : do_up ? inc_v : do_dn ? dec_v : out_q;
        next_d = !load_i && do_up && at_max_o;
        prev_d = !load_i && do_dn && at_min_o;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_q  <= '0;
            next_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            next_q <= next_d;
            prev_q <= prev_d;
        end
    end

    assign out_o  = out_q;
    assign next_o = next_q;
    assign prev_o = prev_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: wrap and saturate instances driven in parallel and
// compared every cycle against an integer model of the count.
module tb_bcd_updown_counter;
    localparam int D    = 4;
    localparam int MAXV = 9999;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, en, up, dn, ld;
    logic [4*D-1:0] lv, ow, os;
    logic          nw, pw, xw, mw, ns, ps, xs, ms;

    int vectors = 0, miscompares = 0;
    int mw_v = 0, ms_v = 0;
    bit mnw, mpw, mns, mps;

    bcd_updown_counter #(.DIGITS(D), .SATURATE(0)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .down_i(dn),
        .load_i(ld), .load_val_i(lv), .out_o(ow), .next_o(nw), .prev_o(pw),
        .at_max_o(xw), .at_min_o(mw)
    );

    bcd_updown_counter #(.DIGITS(D), .SATURATE(1)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_i(up), .down_i(dn),
        .load_i(ld), .load_val_i(lv), .out_o(os), .next_o(ns), .prev_o(ps),
        .at_max_o(xs), .at_min_o(ms)
    );

    function automatic int to_int(logic [4*D-1:0] b);
        int r = 0;
        for (int k = D - 1; k >= 0; k--) r = r * 10 + (b[4*k +: 4] > 4'd9 ? 9 : int'(b[4*k +: 4]));
        return r;
    endfunction

    function automatic logic [4*D-1:0] to_bcd(int v);
        logic [4*D-1:0] r;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(bit sat, inout int v, output bit n, output bit p);
        n = 0;
        p = 0;
        if (!rst_n) v = 0;
        else if (ld) v = to_int(lv);
        else if (en && up && !dn) begin
            if (v != MAXV) v++;
            else if (!sat) begin v = 0; n = 1; end
        end else if (en && dn && !up) begin
            if (v != 0) v--;
            else if (!sat) begin v = MAXV; p = 1; end
        end
    endtask

    task automatic cyc(bit r, bit e, bit u, bit d, bit l, logic [4*D-1:0] v);
        rst_n = r; en = e; up = u; dn = d; ld = l; lv = v;
        @(posedge clk);
        model_step(0, mw_v, mnw, mpw);
        model_step(1, ms_v, mns, mps);
        #1;
        chk("out_w", ow, to_bcd(mw_v));
        chk("next_w", nw, mnw);
        chk("prev_w", pw, mpw);
        chk("atmax_w", xw, mw_v == MAXV);
        chk("atmin_w", mw, mw_v == 0);
        chk("out_s", os, to_bcd(ms_v));
        chk("next_s", ns, mns);
        chk("prev_s", ps, mps);
        chk("atmax_s", xs, ms_v == MAXV);
        chk("atmin_s", ms, ms_v == 0);
    endtask

    initial begin
        logic [4*D-1:0] v;
        cyc(0, 1, 1, 0, 0, 0);
        chk("t1_rst", ow, 16'h0000);
        cyc(1, 1, 1, 0, 0, 0);
        chk("t1_cnt1", ow, 16'h0001);
        cyc(1, 1, 1, 0, 0, 0);
        chk("t1_cnt2", ow, 16'h0002);
        cyc(1, 1, 1, 0, 0, 0);
        chk("t1_cnt3", ow, 16'h0003);
        cyc(1, 0, 0, 0, 1, 16'h0999);
        cyc(1, 1, 1, 0, 0, 0);
        chk("t2_carry", ow, 16'h1000);
        chk("t2_nonext", nw, 1'b0);
        cyc(1, 0, 0, 0, 1, 16'h9999);
        cyc(1, 1, 1, 0, 0, 0);
        chk("t2_wrap", ow, 16'h0000);
        chk("t2_next", nw, 1'b1);
        chk("t4_sat_up", os, 16'h9999);
        cyc(1, 1, 1, 0, 0, 0);
        chk("t2_next_drop", nw, 1'b0);
        chk("t4_sat_up2", os, 16'h9999);
        cyc(1, 1, 1, 0, 0, 0);
        chk("t4_sat_up3", os, 16'h9999);
        chk("t4_nonext", ns, 1'b0);
        cyc(1, 0, 0, 0, 1, 16'h1000);
        cyc(1, 1, 0, 1, 0, 0);
        chk("t3_borrow", ow, 16'h0999);
        cyc(1, 0, 0, 0, 1, 16'h0000);
        cyc(1, 1, 0, 1, 0, 0);
        chk("t3_wrap", ow, 16'h9999);
        chk("t3_prev", pw, 1'b1);
        chk("t4_sat_dn", os, 16'h0000);
        chk("t4_noprev", ps, 1'b0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("t3_prev_drop", pw, 1'b0);
        cyc(1, 0, 0, 0, 1, 16'h0042);
        cyc(1, 1, 1, 1, 0, 0);
        chk("t5_both", ow, 16'h0042);
        cyc(1, 0, 1, 0, 1, 16'h0007);
        chk("t5_load", ow, 16'h0007);
        cyc(1, 0, 1, 0, 0, 0);
        chk("t5_noen", ow, 16'h0007);
        cyc(1, 0, 0, 0, 1, 16'h0A5F);
        chk("t6_clamp", ow, 16'h0959);
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 4))
                0: v = 16'h9999;
                1: v = 16'h0000;
                2: v = 16'h9998;
                3: v = 16'h0001;
                default: v = 16'($urandom);
            endcase
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                1'($urandom), $urandom_range(0, 99) < 5, v);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
